// File: rtl/rdresp_packer.sv
// Read-result packer: frames read-data words into header + payload packets for
// the GTP transmit link, flushing a partial packet after an input idle timeout.
module rdresp_packer #(
  parameter int unsigned PKT_WORDS   = 8,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter logic [7:0]  HDR_TAG     = 8'hA5
) (
  input  logic        core_clk,
  input  logic        rst_n,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [15:0] pkt_cnt
);

  localparam int unsigned AW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam logic [7:0]    PKT_LEN  = 8'(PKT_WORDS);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } state_t;

  function automatic logic [31:0] hdr_word(input logic [7:0] seq, input logic [7:0] len);
    return {HDR_TAG, seq, 8'h00, len};
  endfunction

  state_t        state_r, state_s;
  logic [7:0]    count_r, count_s;
  logic [7:0]    len_r, len_s;
  logic [7:0]    idx_r, idx_s;
  logic [7:0]    seq_r, seq_s;
  logic [TW-1:0] tmo_r, tmo_s;
  logic [15:0]   pkt_cnt_r, pkt_cnt_s;
  logic          s_tready_r, s_tready_s;
  logic          m_tvalid_r, m_tvalid_s;
  logic          m_tlast_r, m_tlast_s;
  logic [31:0]   m_tdata_r, m_tdata_s;
  logic          accept_s, m_hs_s;
  logic [7:0]    count_inc_s, idx_inc_s;
  logic [31:0]   buf_r [0:PKT_WORDS-1];

  assign accept_s    = s_axis_tvalid & s_tready_r;
  assign m_hs_s      = m_tvalid_r & m_axis_tready;
  assign count_inc_s = count_r + 8'd1;
  assign idx_inc_s   = idx_r + 8'd1;

  assign s_axis_tready = s_tready_r;
  assign m_axis_tdata  = m_tdata_r;
  assign m_axis_tvalid = m_tvalid_r;
  assign m_axis_tlast  = m_tlast_r;
  assign pkt_cnt       = pkt_cnt_r;

  // Next-state and next-output computation; outputs are registered from these.
  always_comb begin
    state_s    = state_r;
    count_s    = count_r;
    len_s      = len_r;
    idx_s      = idx_r;
    seq_s      = seq_r;
    tmo_s      = tmo_r;
    pkt_cnt_s  = pkt_cnt_r;
    m_tvalid_s = m_tvalid_r;
    m_tlast_s  = m_tlast_r;
    m_tdata_s  = m_tdata_r;
    s_tready_s = 1'b0;
    case (state_r)
      ST_FILL: begin
        if (accept_s) begin
          // An accept always clears the idle timer, even on the flush cycle.
          count_s = count_inc_s;
          tmo_s   = '0;
          if (count_inc_s == PKT_LEN) begin
            state_s    = ST_HDR;
            len_s      = count_inc_s;
            m_tvalid_s = 1'b1;
            m_tlast_s  = 1'b0;
            m_tdata_s  = hdr_word(seq_r, count_inc_s);
          end else begin
            state_s = ST_FILL;
          end
        end else if (count_r == 8'd0) begin
          tmo_s = '0;
        end else if (tmo_r == TMO_LAST) begin
          state_s    = ST_HDR;
          len_s      = count_r;
          tmo_s      = '0;
          m_tvalid_s = 1'b1;
          m_tlast_s  = 1'b0;
          m_tdata_s  = hdr_word(seq_r, count_r);
        end else begin
          tmo_s = tmo_r + TMO_ONE;
        end
      end
      ST_HDR: begin
        if (m_hs_s) begin
          state_s   = ST_PAY;
          idx_s     = 8'd0;
          m_tdata_s = buf_r[0];
          m_tlast_s = (len_r == 8'd1);
        end else begin
          state_s = ST_HDR;
        end
      end
      ST_PAY: begin
        if (m_hs_s && m_tlast_r) begin
          state_s    = ST_FILL;
          seq_s      = seq_r + 8'd1;
          pkt_cnt_s  = pkt_cnt_r + 16'd1;
          count_s    = 8'd0;
          tmo_s      = '0;
          idx_s      = 8'd0;
          m_tvalid_s = 1'b0;
          m_tlast_s  = 1'b0;
          m_tdata_s  = 32'h0000_0000;
        end else if (m_hs_s) begin
          idx_s     = idx_inc_s;
          m_tdata_s = buf_r[idx_inc_s[AW-1:0]];
          m_tlast_s = (idx_inc_s == (len_r - 8'd1));
        end else begin
          state_s = ST_PAY;
        end
      end
      default: begin
        state_s    = ST_FILL;
        count_s    = 8'd0;
        tmo_s      = '0;
        idx_s      = 8'd0;
        m_tvalid_s = 1'b0;
        m_tlast_s  = 1'b0;
        m_tdata_s  = 32'h0000_0000;
      end
    endcase
    // Ready is derived from the next state so the registered copy tracks state and count.
    if ((state_s == ST_FILL) && (count_s < PKT_LEN)) begin
      s_tready_s = 1'b1;
    end else begin
      s_tready_s = 1'b0;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge core_clk) begin
    if (!rst_n) begin
      state_r    <= ST_FILL;
      count_r    <= 8'd0;
      len_r      <= 8'd0;
      idx_r      <= 8'd0;
      seq_r      <= 8'd0;
      tmo_r      <= '0;
      pkt_cnt_r  <= 16'd0;
      s_tready_r <= 1'b0;
      m_tvalid_r <= 1'b0;
      m_tlast_r  <= 1'b0;
      m_tdata_r  <= 32'h0000_0000;
    end else begin
      state_r    <= state_s;
      count_r    <= count_s;
      len_r      <= len_s;
      idx_r      <= idx_s;
      seq_r      <= seq_s;
      tmo_r      <= tmo_s;
      pkt_cnt_r  <= pkt_cnt_s;
      s_tready_r <= s_tready_s;
      m_tvalid_r <= m_tvalid_s;
      m_tlast_r  <= m_tlast_s;
      m_tdata_r  <= m_tdata_s;
    end
  end

  // Payload buffer, written in arrival order; contents need no reset.
  always_ff @(posedge core_clk) begin
    if (accept_s) begin
      buf_r[count_r[AW-1:0]] <= s_axis_tdata;
    end
  end

endmodule
